// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay_pipe slice.
// Provides the tap-select width function, the per-stage struct macro and the
// priority encoding (reset > flush > stall > shift) used by every register.

`define DELAY_STAGE_T(name_, width_) typedef struct packed { logic valid; logic [(width_)-1:0] data; } name_

package delay_pkg;

  // What a pipeline register does on the next rising edge, highest priority first.
  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_FLUSH = 2'd1,
    OP_HOLD  = 2'd2,
    OP_SHIFT = 2'd3
  } stage_op_t;

  // Width of a selector that must encode 0..depth inclusive.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Single point of truth for the control priority.
  function automatic stage_op_t stage_op(input logic rst_n, input logic flush, input logic stall);
    if (!rst_n)     return OP_RESET;
    else if (flush) return OP_FLUSH;
    else if (stall) return OP_HOLD;
    else            return OP_SHIFT;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One delay-line register carrying data plus a valid bit.
// Ports: clk_i, rst_ni (sync, active-low), stall_i, flush_i, valid_i/data_i in,
//        valid_o/data_o registered out (one cycle latency, holds while stalled).

module delay_stage
  import delay_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  `DELAY_STAGE_T(stage_t, WIDTH);

  stage_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    unique case (stage_op(rst_ni, flush_i, stall_i))
      OP_RESET, OP_FLUSH: stage_d = '{valid: 1'b0, data: RESET_VALUE};
      OP_HOLD:            stage_d = stage_q;
      OP_SHIFT: begin
        stage_d.valid = valid_i;
        // Bubbles are scrubbed so an invalid stage never carries stale data.
        stage_d.data  = valid_i ? data_i : RESET_VALUE;
      end
      default:            stage_d = stage_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) stage_q <= '{valid: 1'b0, data: RESET_VALUE};
    else         stage_q <= stage_d;
  end

  assign valid_o = stage_q.valid;
  assign data_o  = stage_q.data;

endmodule

// File: rtl/delay_pipe.sv
// DEPTH-stage WIDTH-bit delay line with per-stage valid, stall, flush, tap mux and count.
// Ports: clk_i, rst_ni (sync, active-low), stall_i, flush_i, in_valid_i, in_i, tap_sel_i;
//        out_o/out_valid_o (comb tap), taps_o/taps_valid_o (all stages), count_o (registered).

module delay_pipe
  import delay_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              SELW        = sel_width(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  input  logic [WIDTH-1:0]       in_i,
  input  logic [SELW-1:0]        tap_sel_i,
  output logic [WIDTH-1:0]       out_o,
  output logic                   out_valid_o,
  output logic [DEPTH*WIDTH-1:0] taps_o,
  output logic [DEPTH-1:0]       taps_valid_o,
  output logic [SELW-1:0]        count_o
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("delay_pipe: DEPTH must be >= 1");
  end

  logic             stg_vld [DEPTH];
  logic [WIDTH-1:0] stg_dat [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      assign vin = in_valid_i;
      assign din = in_i;
    end else begin : g_body
      assign vin = stg_vld[i-1];
      assign din = stg_dat[i-1];
    end

    delay_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .valid_i (vin),
      .data_i  (din),
      .valid_o (stg_vld[i]),
      .data_o  (stg_dat[i])
    );

    assign taps_o[i*WIDTH +: WIDTH] = stg_dat[i];
    assign taps_valid_o[i]          = stg_vld[i];
  end

  // Occupancy tracks the valid bits incrementally. Modular SELW arithmetic is
  // exact here: when full, a valid input is always paired with a valid drop.
  logic [SELW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case (stage_op(rst_ni, flush_i, stall_i))
      OP_RESET, OP_FLUSH: count_d = '0;
      OP_HOLD:            count_d = count_q;
      OP_SHIFT:           count_d = count_q + SELW'(in_valid_i) - SELW'(stg_vld[DEPTH-1]);
      default:            count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

  // Tap 0 is the live input; taps beyond DEPTH clamp to the oldest stage.
  always_comb begin
    out_o       = in_i;
    out_valid_o = in_valid_i;
    for (int k = 0; k < DEPTH; k++) begin
      if ((int'(tap_sel_i) == k + 1) || ((k == DEPTH - 1) && (int'(tap_sel_i) > DEPTH))) begin
        out_o       = stg_dat[k];
        out_valid_o = stg_vld[k];
      end
    end
  end

endmodule

// File: tb/tb_delay_pipe.sv
module tb_delay_pipe;

  localparam int W    = 4;
  localparam int D    = 2;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst_n, stall, flush, in_valid;
  logic [W-1:0]      in_dat;
  logic [SELW-1:0]   tap_sel;
  logic [W-1:0]      out_dat;
  logic              out_valid;
  logic [D*W-1:0]    taps;
  logic [D-1:0]      taps_valid;
  logic [SELW-1:0]   count;

  always #5 clk = ~clk;

  delay_pipe #(
    .WIDTH       (W),
    .DEPTH       (D),
    .RESET_VALUE (4'h0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_i         (in_dat),
    .tap_sel_i    (tap_sel),
    .out_o        (out_dat),
    .out_valid_o  (out_valid),
    .taps_o       (taps),
    .taps_valid_o (taps_valid),
    .count_o      (count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a fixed-length queue, index 0 = youngest stage.
  typedef struct {
    bit         v;
    logic [W-1:0] d;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('{v: 1'b0, d: '0});
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].v) n++;
    return n;
  endfunction

  // Apply inputs, check the combinational tap, clock once, update the model
  // and compare every registered output.
  task automatic step(input bit r, input bit s, input bit f, input bit v,
                      input logic [W-1:0] d, input logic [SELW-1:0] sel);
    int   idx;
    ent_t e;
    rst_n = r; stall = s; flush = f; in_valid = v; in_dat = d; tap_sel = sel;
    #1;
    if (sel == 0) begin
      e.v = v; e.d = d;
    end else begin
      idx = (int'(sel) > D) ? D - 1 : int'(sel) - 1;
      e = mq[idx];
    end
    chk("out", out_dat, e.d);
    chk("out_valid", out_valid, e.v);
    @(posedge clk);
    if (!r || f) model_clear();
    else if (!s) begin
      mq.push_front(v ? '{v: 1'b1, d: d} : '{v: 1'b0, d: '0});
      void'(mq.pop_back());
    end
    #1;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("tap%0d", i), taps[i*W +: W], mq[i].d);
      chk($sformatf("tap_valid%0d", i), taps_valid[i], mq[i].v);
    end
    chk("count", count, model_count());
    chk("count_popcount", count, $countones(taps_valid));
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dat = '0; tap_sel = '0;

    // Reset held two edges with a valid input present.
    step(0, 0, 0, 1, 4'hF, 2);
    step(0, 0, 0, 1, 4'hF, 2);
    chk("reset_taps", taps, 8'h00);
    chk("reset_count", count, 0);

    // Streaming 1,2,3 at tap 2.
    step(1, 0, 0, 1, 4'h1, 2);
    chk("stream_cnt1", count, 1);
    step(1, 0, 0, 1, 4'h2, 2);
    chk("stream_cnt2", count, 2);
    step(1, 0, 0, 1, 4'h3, 2);
    chk("stream_taps", taps, 8'h23);
    #1; chk("stream_out2", out_dat, 4'h2);

    // Stall three edges with in=9 offered.
    repeat (3) step(1, 1, 0, 1, 4'h9, 2);
    chk("stall_taps", taps, 8'h23);
    chk("stall_count", count, 2);
    step(1, 0, 0, 1, 4'h4, 2);
    chk("release_taps", taps, 8'h34);

    // Flush wins over stall; next shift starts fresh.
    step(1, 1, 1, 1, 4'h7, 1);
    chk("flush_taps", taps, 8'h00);
    chk("flush_count", count, 0);
    step(1, 0, 0, 1, 4'h5, 1);
    chk("post_flush_taps", taps, 8'h05);
    chk("post_flush_count", count, 1);

    // Bubbles and tap mux (flush first to get an empty pipe).
    step(1, 0, 1, 0, 4'h0, 0);
    step(1, 0, 0, 1, 4'hA, 0);
    chk("bub_v0", taps_valid, 2'b01);
    step(1, 0, 0, 0, 4'hE, 3);
    chk("bub_v1", taps_valid, 2'b10);
    chk("bub_scrub", taps, 8'hA0);
    step(1, 0, 0, 1, 4'hB, 1);
    chk("bub_v2", taps_valid, 2'b01);
    chk("bub_count", count, 1);
    step(1, 0, 0, 1, 4'hC, 3);
    step(1, 0, 0, 0, 4'h6, 0);

    // Mid-stream reset at count 2, then resume.
    step(1, 0, 0, 1, 4'h1, 2);
    step(1, 0, 0, 1, 4'h2, 2);
    step(0, 1, 1, 1, 4'h8, 2);
    chk("midreset_taps", taps, 8'h00);
    step(1, 0, 0, 1, 4'h3, 2);
    chk("resume_count", count, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(99) >= 3), ($urandom_range(99) < 20), ($urandom_range(99) < 5),
           ($urandom_range(99) < 70), W'($urandom), SELW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_pipe.md
Name: delay_pipe

Overview:
- Parametrised successor to the plain fixed-latency delay array: a DEPTH-stage, WIDTH-bit delay line where each stage carries a valid bit.
- Adds pipeline stall (hold), flush (bubble insertion), a runtime-selectable output tap, and a registered occupancy count.
- Used in the pipelined MIPS datapath to align side-band data (PC, dest reg, control words) with stages that can stall or be squashed.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 4, number of register stages; must be >= 1; elaboration error otherwise.
- RESET_VALUE, 0, WIDTH-bit value loaded into every stage on reset, flush, or bubble.

Ports:
- ctrl.Clock  input  1  single clock; all state updates on the rising edge.
- ctrl.Reset  input  1  synchronous, active-low reset, carried in the Util_Control bundle.
- stall  input  1  hold all stages when 1.
- flush  input  1  invalidate all stages when 1.
- in_valid  input  1  qualifies in.
- in  input  WIDTH  data entering stage 0.
- tap_sel  input  SELW=$clog2(DEPTH+1)  output tap: 0 = combinational pass-through, k = stage k-1.
- out  output  WIDTH  selected tap data.
- out_valid  output  1  selected tap valid.
- taps  output  DEPTH*WIDTH  all stage registers; stage i at bits [i*WIDTH +: WIDTH].
- taps_valid  output  DEPTH  valid bit per stage.
- count  output  SELW  number of valid stages, registered.

Behaviour:
- Priority per rising edge, highest first: reset (Reset==0), then flush, then stall, then shift.
- Reset:
  - All stage data = RESET_VALUE, all valid = 0, count = 0.
  - Visible the cycle after the edge.
  - Reset dominates everything, including a reset asserted mid-stall or mid-flush.
- Flush:
  - All data = RESET_VALUE, all valid = 0, count = 0.
  - in and in_valid on that edge are discarded.
  - Flush with stall still clears.
- Stall (no flush): every stage, valid bit and count hold; in is dropped.
- Shift:
  - stage[0] <= in_valid ? in : RESET_VALUE; valid[0] <= in_valid.
  - stage[i] <= stage[i-1], valid[i] <= valid[i-1] for i = 1..DEPTH-1.
  - The oldest entry falls off.
- Latency: without stalls, data entering at edge n appears on stage k-1 after edge n+k-1 (tap k).
  - Example: tap k=DEPTH gives DEPTH cycles of latency.
- count on shift: count_next = count + in_valid - valid[DEPTH-1]. It never exceeds DEPTH and never goes below 0.
  - The bench asserts count == popcount(taps_valid) every cycle.
- out / out_valid (combinational mux):
  - tap_sel==0 gives in/in_valid.
  - 1 <= tap_sel <= DEPTH gives stage[tap_sel-1].
  - tap_sel > DEPTH clamps to stage[DEPTH-1].
- Invalid stages always hold RESET_VALUE. A bubble never carries stale data.
- Full: count==DEPTH. A valid input while full shifts normally; the oldest entry is lost with no error flag. Empty: count==0.
- With DEPTH=1, taps == stage[0] and SELW=1.

Decomposition:
- Package delay_pkg holds:
  - function sel_width(depth) returning $clog2(depth+1);
  - a delay_stage_t struct {logic valid; logic [WIDTH-1:0] data} helper via parametrised typedef macro;
  - the priority-encoding localparams.
- Sub-module delay_stage: one register with valid, stall, flush and reset priority. Instantiated DEPTH times via generate.
- The top level owns the count register and the tap mux.

Test Plan:
All tests use WIDTH=4, DEPTH=2, RESET_VALUE=0.
- Reset: hold Reset=0 for 2 edges with in=4'hF, in_valid=1 -> taps=0, taps_valid=2'b00, count=0, out=0 for tap_sel=2.
- Streaming: Reset=1, in_valid=1, in=1,2,3,… per edge, tap_sel=2 -> out=1 two edges after 1 was applied, then 2, 3. count goes 1, 2, 2. out_valid=1 from the second edge.
- Stall: at count=2, taps={2,3}, assert stall 3 edges while in=9 -> taps stay {2,3}, count=2. Release -> next edge stage0=in, stage1=3.
- Flush priority: stall=1, flush=1, in_valid=1, in=7 -> taps=0, taps_valid=0, count=0. Next shift with in=5 -> stage0=5, count=1.
- Bubbles and tap mux: inputs A (valid), x (invalid), B (valid) -> taps_valid cycles 01, 10, 01 and count 1, 1, 1. The invalid stage reads 0. tap_sel=0 echoes in; tap_sel=3 clamps to stage1.
- Mid-operation reset: Reset=0 for one edge during streaming at count=2 -> next cycle all zero. Streaming resumes from count=1.
